q1b_eval_arbiter: RTL and testbench

//   Shares one registered instance of the q1_b AND-OR function, o = ((a&b&c)|(d&e))&f,

---
 rtl/q1b_eval_arbiter.sv | 159 +++++++++++++++
 tb/tb_q1b_eval_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/q1b_eval_arbiter.sv
// q1b_eval_arbiter
// Round-robin front end for a single shared evaluator of o = ((a&b&c)|(d&e))&f.
// One requester is granted per operation. Its 6-bit operand is captured on the
// grant edge and evaluated EVAL_LAT edges later. The result is returned with the
// owner's index as a one-cycle res_valid pulse.

module q1b_eval_arbiter #(
    parameter int NREQ     = 4,   // number of requesters, 2..8
    parameter int EVAL_LAT = 2    // grant edge to result edge, 1..15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req,
    input  logic [6*NREQ-1:0]   op_data,
    output logic [NREQ-1:0]     gnt,
    output logic                busy,
    output logic                res_valid,
    output logic [2:0]          res_id,
    output logic                res_out
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EVAL = 1'b1
    } state_t;

    // Operand bit order: bit5=a, bit4=b, bit3=c, bit2=d, bit1=e, bit0=f.
    function automatic logic q1b_f(input logic [5:0] op);
        logic a, b, c, d, e, f;
        {a, b, c, d, e, f} = op;
        return ((a & b & c) | (d & e)) & f;
    endfunction

    state_t          r_state;
    state_t          w_state_nxt;
    logic [2:0]      r_rr_ptr;
    logic [2:0]      r_id;
    logic [5:0]      r_op;
    logic [3:0]      r_cnt;
    logic [NREQ-1:0] r_gnt;
    logic            r_res_valid;
    logic [2:0]      r_res_id;
    logic            r_res_out;

    logic [NREQ-1:0] w_rot;
    logic            w_found;
    logic [2:0]      w_win;
    logic [3:0]      w_sum;
    logic [5:0]      w_op;
    logic [NREQ-1:0] w_gnt_1h;
    logic [2:0]      w_ptr_nxt;
    logic            w_take;
    logic            w_done;

    // Rotate req so bit 0 is the requester at rr_ptr, then take the first set bit
    // and map the offset back to an absolute requester index.
    always_comb begin
        w_rot   = NREQ'({req, req} >> r_rr_ptr);
        w_found = 1'b0;
        w_win   = 3'd0;
        w_sum   = 4'd0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, r_rr_ptr} + 4'(k);
                if (w_sum >= 4'(NREQ)) begin
                    w_sum = w_sum - 4'(NREQ);
                end
                w_win = w_sum[2:0];
            end
        end
    end

    // Decode the winner into its one-hot grant, its operand slice and the next pointer.
    always_comb begin
        w_op     = 6'd0;
        w_gnt_1h = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == 3'(i)) begin
                w_op        = op_data[6*i +: 6];
                w_gnt_1h[i] = 1'b1;
            end
        end
        w_ptr_nxt = (w_win == 3'(NREQ - 1)) ? 3'd0 : (w_win + 3'd1);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: arbitrate in IDLE, count down in EVAL and return when the counter is spent.
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_take      = 1'b1;
                    w_state_nxt = S_EVAL;
                end
            end
            S_EVAL: begin
                if (r_cnt == 4'd0) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Grant, operand capture, latency counter and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt       <= '0;
            r_op        <= 6'd0;
            r_id        <= 3'd0;
            r_cnt       <= 4'd0;
            r_rr_ptr    <= 3'd0;
            r_res_valid <= 1'b0;
            r_res_id    <= 3'd0;
            r_res_out   <= 1'b0;
        end else begin
            // gnt and res_valid are single-cycle pulses unless re-armed below.
            r_gnt       <= '0;
            r_res_valid <= 1'b0;
            if (w_take) begin
                r_gnt    <= w_gnt_1h;
                r_op     <= w_op;
                r_id     <= w_win;
                r_cnt    <= 4'(EVAL_LAT - 1);
                r_rr_ptr <= w_ptr_nxt;
            end
            if (r_state == S_EVAL && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_done) begin
                r_res_out   <= q1b_f(r_op);
                r_res_id    <= r_id;
                r_res_valid <= 1'b1;
            end
        end
    end

    assign gnt       = r_gnt;
    assign busy      = (r_state == S_EVAL);
    assign res_valid = r_res_valid;
    assign res_id    = r_res_id;
    assign res_out   = r_res_out;

endmodule

// File: tb/tb_q1b_eval_arbiter.sv
// Bench for q1b_eval_arbiter: one instance with EVAL_LAT=2 and one with EVAL_LAT=1.
// Expected results are queued when requests are driven and compared when res_valid fires.

module tb_q1b_eval_arbiter;

    typedef struct {
        int   id;
        logic out;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req0 = '0;
    logic [23:0] op0 = '0;
    logic [3:0]  gnt0;
    logic        busy0, rv0, out0;
    logic [2:0]  id0;
    logic [3:0]  req1 = '0;
    logic [23:0] op1 = '0;
    logic [3:0]  gnt1;
    logic        busy1, rv1, out1;
    logic [2:0]  id1;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;

    q1b_eval_arbiter #(.NREQ(4), .EVAL_LAT(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req(req0), .op_data(op0),
        .gnt(gnt0), .busy(busy0), .res_valid(rv0), .res_id(id0), .res_out(out0)
    );

    q1b_eval_arbiter #(.NREQ(4), .EVAL_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .op_data(op1),
        .gnt(gnt1), .busy(busy1), .res_valid(rv1), .res_id(id1), .res_out(out1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: f gates everything; then either a,b,c all set or d,e both set.
    function automatic logic ref_f(input logic [5:0] v);
        return v[0] && ((v[5:3] == 3'b111) || (v[2:1] == 2'b11));
    endfunction

    // Result scoreboards.
    always @(negedge clk) begin
        if (rst_n && rv0) begin
            if (q0.size() == 0) begin
                chk("res0_unexpected", 32'd1, 32'd0);
            end else begin
                e0 = q0.pop_front();
                chk("res0_id", 32'(id0), e0.id);
                chk("res0_out", 32'(out0), 32'(e0.out));
            end
        end
        if (rst_n && rv1) begin
            if (q1.size() == 0) begin
                chk("res1_unexpected", 32'd1, 32'd0);
            end else begin
                e1 = q1.pop_front();
                chk("res1_id", 32'(id1), e1.id);
                chk("res1_out", 32'(out1), 32'(e1.out));
            end
        end
    end

    task automatic wait_gnt0(input logic [3:0] exp, input string tag, output int at);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt0 == 4'd0 && n < 20);
        at = cyc;
        chk(tag, 32'(gnt0), 32'(exp));
    endtask

    task automatic drain0(input string tag);
        int n;
        n = 0;
        while (q0.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(tag, q0.size(), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [5:0] tv_op  [4];
        logic       tv_exp [4];
        logic [5:0] v;
        int         t      [6];
        int         ids    [6];
        int         at;
        logic       ev_rv  [4];
        logic       ev_bz  [4];

        tv_op[0] = 6'b000111; tv_exp[0] = 1'b1;
        tv_op[1] = 6'b111110; tv_exp[1] = 1'b0;
        tv_op[2] = 6'b110011; tv_exp[2] = 1'b0;
        tv_op[3] = 6'b111111; tv_exp[3] = 1'b1;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_gnt", 32'(gnt0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_rv", 32'(rv0), 32'd0);
        chk("rst_id", 32'(id0), 32'd0);
        chk("rst_out", 32'(out0), 32'd0);
        chk("rst_gnt1", 32'(gnt1), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single request on req[2], operand 111001, EVAL_LAT=2.
        op0[17:12] = 6'b111001;
        req0 = 4'b0100;
        q0.push_back('{2, 1'b1});
        @(negedge clk);
        chk("t1_gnt", 32'(gnt0), 32'b0100);
        chk("t1_busy", 32'(busy0), 32'd1);
        chk("t1_rv_a", 32'(rv0), 32'd0);
        req0 = 4'b0000;
        @(negedge clk);
        chk("t1_gnt_off", 32'(gnt0), 32'd0);
        chk("t1_rv_b", 32'(rv0), 32'd0);
        chk("t1_busy_b", 32'(busy0), 32'd1);
        @(negedge clk);
        chk("t1_rv_c", 32'(rv0), 32'd1);
        chk("t1_busy_c", 32'(busy0), 32'd0);
        @(negedge clk);
        chk("t1_rv_d", 32'(rv0), 32'd0);
        drain0("t1_drain");

        // Wrap: rr_ptr is 3, req=0101 gives req[0], then req[2].
        op0[5:0]   = 6'b000111;
        op0[17:12] = 6'b111110;
        req0 = 4'b0101;
        q0.push_back('{0, 1'b1});
        wait_gnt0(4'b0001, "t4_wrap", at);
        q0.push_back('{2, 1'b0});
        wait_gnt0(4'b0100, "t4_next", at);
        req0 = 4'b0000;
        drain0("t4_drain");

        // EVAL_LAT=1 instance: req[1] then req[3] back-to-back.
        op1[11:6]  = 6'b000111;
        op1[23:18] = 6'b110011;
        req1 = 4'b1010;
        q1.push_back('{1, 1'b1});
        q1.push_back('{3, 1'b0});
        ev_rv[0] = 1'b0; ev_bz[0] = 1'b1;
        ev_rv[1] = 1'b1; ev_bz[1] = 1'b0;
        ev_rv[2] = 1'b0; ev_bz[2] = 1'b1;
        ev_rv[3] = 1'b1; ev_bz[3] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t6_rv", 32'(rv1), 32'(ev_rv[k]));
            chk("t6_busy", 32'(busy1), 32'(ev_bz[k]));
            if (k == 0) begin
                chk("t6_gnt_a", 32'(gnt1), 32'b0010);
                req1 = 4'b1000;
            end
            if (k == 2) begin
                chk("t6_gnt_b", 32'(gnt1), 32'b1000);
                req1 = 4'b0000;
            end
        end
        @(negedge clk);
        chk("t6_drain", q1.size(), 32'd0);

        // Listed function vectors via req[0]; operand scrambled after the grant.
        for (int k = 0; k < 4; k++) begin
            op0[5:0] = tv_op[k];
            req0 = 4'b0001;
            q0.push_back('{0, tv_exp[k]});
            wait_gnt0(4'b0001, "t2_gnt", at);
            req0 = 4'b0000;
            op0[5:0] = ~tv_op[k];
            drain0("t2_drain");
        end

        // Full operand sweep against the reference model.
        for (int k = 0; k < 64; k++) begin
            v = 6'(k);
            op0[5:0] = v;
            req0 = 4'b0001;
            q0.push_back('{0, ref_f(v)});
            wait_gnt0(4'b0001, "t2s_gnt", at);
            req0 = 4'b0000;
            op0[5:0] = ~v;
            drain0("t2s_drain");
        end

        // Reset mid-EVAL: rr_ptr is 1, so req[1] is granted, then discarded.
        op0[11:6] = 6'b111111;
        req0 = 4'b0010;
        wait_gnt0(4'b0010, "t5_gnt", at);
        req0 = 4'b0000;
        @(negedge clk);
        chk("t5_busy_pre", 32'(busy0), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_gnt", 32'(gnt0), 32'd0);
        chk("t5_busy", 32'(busy0), 32'd0);
        chk("t5_rv", 32'(rv0), 32'd0);
        chk("t5_id", 32'(id0), 32'd0);
        chk("t5_out", 32'(out0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t5_no_rv", 32'(rv0), 32'd0);
        end

        // All four held: 0,1,2,3,0,1 with EVAL_LAT+1 spacing.
        op0 = {6'b111111, 6'b000111, 6'b111001, 6'b110011};
        ids[0] = 0; ids[1] = 1; ids[2] = 2; ids[3] = 3; ids[4] = 0; ids[5] = 1;
        for (int k = 0; k < 6; k++) begin
            q0.push_back('{ids[k], ref_f(op0[6*ids[k] +: 6])});
        end
        req0 = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            wait_gnt0(4'b0001 << ids[k], "t3_gnt", t[k]);
            if (k == 5) req0 = 4'b0000;
            if (k > 0) chk("t3_spacing", t[k] - t[k-1], 32'd3);
        end
        drain0("t3_drain");
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
